moore_overlapping: RTL and testbench

- Moore-type serial sequence detector. Samples a 1-bit serial input on every rising clock edge.
- Raises a single-cycle flag after the programmed bit pattern has been received, most recent bit last. Default pattern is 1011.
- Detection is overlapping: the trailing bits of one match may start the next match.
- Used as a leaf block on serial control/data lines; the flag feeds downstream event logic.

---
 rtl/moore_overlapping.sv | 106 ++++++++++
 tb/tb_moore_overlapping.sv | 116 +++++++++++
 2 files changed

// File: rtl/moore_overlapping.sv
// Overlapping Moore sequence detector: pulses out for one cycle whenever the last SEQ_LEN input bits equal SEQ.
// Define MOORE_OVERLAPPING_CHECK_EN to compile in simulation-only state/output checks and detection messages.
module moore_overlapping #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam int              SW   = $clog2(SEQ_LEN + 1);
    localparam logic [SW-1:0]   LAST = SW'(SEQ_LEN);

    // Longest prefix of SEQ that ends the string (first k pattern bits, then b).
    // For k < SEQ_LEN a matching bit gives k+1; from k == SEQ_LEN this is the overlap path.
    function automatic logic [SW-1:0] next_prefix_len(input int k, input logic b);
        logic [SEQ_LEN:0] str;
        int               best;
        bit               ok;
        str  = '0;
        best = 0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            str[i] = SEQ[SEQ_LEN-1-i];
        end
        str[k] = b;
        for (int len = 1; len <= SEQ_LEN; len++) begin
            if (len <= k + 1) begin
                ok = 1'b1;
                for (int j = 0; j < len; j++) begin
                    if (str[k+1-len+j] != SEQ[SEQ_LEN-1-j]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = len;
                end
            end
        end
        return SW'(best);
    endfunction

    logic [SW-1:0] state;
    logic [SW-1:0] next_state;
    logic [SW-1:0] next_on_zero [2**SW];
    logic [SW-1:0] next_on_one  [2**SW];

    // Unused encodings above SEQ_LEN fall back to state 0.
    for (genvar k = 0; k < 2**SW; k++) begin : g_table
        if (k <= SEQ_LEN) begin : g_legal
            assign next_on_zero[k] = next_prefix_len(k, 1'b0);
            assign next_on_one[k]  = next_prefix_len(k, 1'b1);
        end else begin : g_illegal
            assign next_on_zero[k] = '0;
            assign next_on_one[k]  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = next_on_zero[state];
        if (in) begin
            next_state = next_on_one[state];
        end
    end

    always_comb begin
        out = (state == LAST);
    end

`ifdef MOORE_OVERLAPPING_CHECK_EN
    // Back-to-back detections are legal only when a full match can extend into another full match.
    localparam bit REPEAT_OK = (next_prefix_len(SEQ_LEN, 1'b0) == LAST) ||
                               (next_prefix_len(SEQ_LEN, 1'b1) == LAST);

    logic out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out;
            if (state > LAST) begin
                $error("moore_overlapping: state %0d exceeds %0d", state, SEQ_LEN);
            end
            if (out && out_q && !REPEAT_OK) begin
                $error("moore_overlapping: out high on consecutive cycles at %0t", $time);
            end
            if (out) begin
                $display("moore_overlapping: detection at %0t", $time);
            end
        end
    end
`else
    // Checks compiled out; the datapath above is the whole design.
`endif

endmodule

// File: tb/tb_moore_overlapping.sv
// Directed bench for moore_overlapping: default 1011 detector and a SEQ_LEN=3 / 111 instance share clk, rst and in.
module tb_moore_overlapping;

    logic clk = 1'b0;
    logic rst;
    logic in;
    logic out;
    logic out3;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    moore_overlapping dut (
        .clk(clk),
        .rst(rst),
        .in (in),
        .out(out)
    );

    moore_overlapping #(.SEQ_LEN(3), .SEQ(3'b111)) dut3 (
        .clk(clk),
        .rst(rst),
        .in (in),
        .out(out3)
    );

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Entered and left on a falling edge; releases reset well away from the rising edge.
    task automatic resetDut();
        rst = 1'b0;
        in  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives bits MSB-first, one per cycle, and checks both detectors just after each rising edge.
    task automatic applyStimulus(input string tag, input logic [15:0] bits,
                                 input logic [15:0] exp, input logic [15:0] exp3, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            in = bits[i];
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s bit%0d", tag, n - i), out, exp[i]);
            checkOutput($sformatf("%s len3 bit%0d", tag, n - i), out3, exp3[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        in  = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            in = (i < 3) ? 1'b1 : i[0];
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset hold %0d", i), out, 1'b0);
            checkOutput($sformatf("reset hold len3 %0d", i), out3, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;

        applyStimulus("basic", 16'b10110, 16'b00010, 16'b00000, 5);

        resetDut();
        applyStimulus("overlap", 16'b1011011, 16'b0001001, 16'b0000000, 7);

        resetDut();
        applyStimulus("near 1001011", 16'b1001011, 16'b0000001, 16'b0000000, 7);

        resetDut();
        applyStimulus("near 11011", 16'b11011, 16'b00001, 16'b00000, 5);

        resetDut();
        applyStimulus("async pre", 16'b1011, 16'b0001, 16'b0000, 4);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async drop", out, 1'b0);
        checkOutput("async drop len3", out3, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        resetDut();
        applyStimulus("mid pre", 16'b101, 16'b000, 16'b000, 3);
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        applyStimulus("mid post", 16'b1011, 16'b0001, 16'b0000, 4);

        resetDut();
        applyStimulus("ones", 16'b111110, 16'b000000, 16'b001110, 6);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
